// File: rtl/led_display_scheduler.sv
// ============================================================================
// led_display_scheduler : steps the LEDs across four sources (manual/auto) or
//                         a CPU hold value. Rev 1.0
// ============================================================================
`default_nettype none

module led_display_scheduler #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int DWELL_CYCLES    = 100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Src0,
  input  logic [31:0] Src1,
  input  logic [31:0] Src2,
  input  logic [31:0] Src3,
  input  logic        Change,
  input  logic        AutoMode,
  input  logic        HoldReq,
  input  logic [31:0] HoldData,
  output logic        HoldAck,
  output logic [1:0]  Sel,
  output logic [31:0] LedShow
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic            sync1_q, sync2_q, stable_q, press_q;
  logic            stable_d, press_d;
  logic [DB_W-1:0] dbcnt_q, dbcnt_d;
  logic [1:0]      state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [31:0]     led_q, led_d;
  logic            hold_ack_q, hold_ack_d;

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES stable cycles.
  always_comb begin
    stable_d = stable_q;
    dbcnt_d  = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (dbcnt_q == DB_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        dbcnt_d = dbcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_MANUAL: begin
        if (HoldReq) begin
          state_d = ST_HOLD;
        end else if (AutoMode) begin
          state_d = ST_AUTO;
          dwell_d = '0;
        end else if (press_q) begin
          sel_d = sel_q + 2'd1;
        end
      end
      ST_AUTO: begin
        if (HoldReq) begin
          state_d = ST_HOLD;
        end else if (!AutoMode) begin
          state_d = ST_MANUAL;
          dwell_d = '0;
        end else if (press_q || (dwell_q == DW_LAST)) begin
          sel_d   = sel_q + 2'd1;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_HOLD: begin
        // Sel and dwell stay frozen; presses seen here are dropped.
        if (!HoldReq) begin
          state_d = AutoMode ? ST_AUTO : ST_MANUAL;
          dwell_d = '0;
        end
      end
      default: begin
        state_d = ST_MANUAL;
        dwell_d = '0;
      end
    endcase
  end

  always_comb begin
    led_d = Src0;
    if (state_q == ST_HOLD) begin
      led_d = HoldData;
    end else begin
      case (sel_q)
        2'd0:    led_d = Src0;
        2'd1:    led_d = Src1;
        2'd2:    led_d = Src2;
        default: led_d = Src3;
      endcase
    end
    hold_ack_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stable_q   <= 1'b0;
      press_q    <= 1'b0;
      dbcnt_q    <= '0;
      state_q    <= ST_MANUAL;
      sel_q      <= 2'd0;
      dwell_q    <= '0;
      led_q      <= 32'd0;
      hold_ack_q <= 1'b0;
    end else begin
      sync1_q    <= Change;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      press_q    <= press_d;
      dbcnt_q    <= dbcnt_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      dwell_q    <= dwell_d;
      led_q      <= led_d;
      hold_ack_q <= hold_ack_d;
    end
  end

  assign HoldAck = hold_ack_q;
  assign Sel     = sel_q;
  assign LedShow = led_q;

endmodule

`default_nettype wire

// File: tb/tb_led_display_scheduler.sv
// ============================================================================
// tb_led_display_scheduler : directed stimulus with an edge-tagged scoreboard.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_led_display_scheduler;

  logic        clk;
  logic        rst_n;
  logic [31:0] src0, src1, src2, src3, hold_data;
  logic        change, auto_mode, hold_req;
  logic        hold_ack;
  logic [1:0]  sel;
  logic [31:0] led;

  logic [31:0] src_v [4];
  localparam logic [31:0] HOLDV = 32'hFFFF_0000;

  led_display_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES   (8)
  ) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .Src0    (src0),
    .Src1    (src1),
    .Src2    (src2),
    .Src3    (src3),
    .Change  (change),
    .AutoMode(auto_mode),
    .HoldReq (hold_req),
    .HoldData(hold_data),
    .HoldAck (hold_ack),
    .Sel     (sel),
    .LedShow (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          e;
    logic [1:0]  sel;
    logic [31:0] led;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected outputs after rising edge number e, kept sorted by edge.
  function automatic void expect_at(int e, logic [1:0] s, logic [31:0] l, logic a);
    exp_t x;
    int   i;
    x.e = e; x.sel = s; x.led = l; x.ack = a;
    i = q.size();
    while (i > 0 && q[i-1].e > e) i--;
    q.insert(i, x);
  endfunction

  task automatic wait_edge(int e);
    while (edge_n < e) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t x;
    while (q.size() > 0 && q[0].e <= edge_n) begin
      x = q.pop_front();
      n_cmp++;
      if (x.e != edge_n || sel !== x.sel || led !== x.led || hold_ack !== x.ack) begin
        n_bad++;
        $display("FAIL out@edge%0d (now %0d): got sel=%0d led=%h ack=%b, want sel=%0d led=%h ack=%b",
                 x.e, edge_n, sel, led, hold_ack, x.sel, x.led, x.ack);
      end
    end
  end

  always @(posedge clk) begin
    if (edge_n > 3000) begin
      $display("FAIL watchdog: edge=%0d, limit 3000", edge_n);
      $fatal(1, "watchdog");
    end
  end

  task automatic do_press(logic [1:0] s0, logic [1:0] s1);
    int b;
    b = edge_n;
    change = 1'b1;
    expect_at(b + 6, s0, src_v[s0], 1'b0);
    expect_at(b + 7, s1, src_v[s0], 1'b0);
    expect_at(b + 8, s1, src_v[s1], 1'b0);
    wait_edge(b + 20);
    change = 1'b0;
    wait_edge(b + 40);
  endtask

  initial begin
    int b, a, r;
    src_v[0] = 32'hA0; src_v[1] = 32'hB1; src_v[2] = 32'hC2; src_v[3] = 32'hD3;
    src0 = src_v[0]; src1 = src_v[1]; src2 = src_v[2]; src3 = src_v[3];
    hold_data = HOLDV;
    rst_n = 1'b0; change = 1'b1; auto_mode = 1'b1; hold_req = 1'b1;

    // Reset with busy inputs, then release.
    for (int k = 1; k <= 3; k++) expect_at(k, 2'd0, 32'd0, 1'b0);
    expect_at(4, 2'd0, 32'hA0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      wait_edge(k);
      change = ~change; auto_mode = ~auto_mode; hold_req = ~hold_req;
    end
    wait_edge(3);
    rst_n = 1'b1; change = 1'b0; auto_mode = 1'b0; hold_req = 1'b0;
    wait_edge(6);

    // Clean presses with wrap.
    do_press(2'd0, 2'd1);
    do_press(2'd1, 2'd2);
    do_press(2'd2, 2'd3);
    do_press(2'd3, 2'd0);
    do_press(2'd0, 2'd1);

    // Bounce shorter than the debounce window.
    b = edge_n;
    change = 1'b1;
    wait_edge(b + 3); change = 1'b0;
    wait_edge(b + 5); change = 1'b1;
    wait_edge(b + 8); change = 1'b0;
    expect_at(b + 9,  2'd1, 32'hB1, 1'b0);
    expect_at(b + 15, 2'd1, 32'hB1, 1'b0);
    expect_at(b + 20, 2'd1, 32'hB1, 1'b0);
    wait_edge(b + 20);
    do_press(2'd1, 2'd2);
    do_press(2'd2, 2'd3);
    do_press(2'd3, 2'd0);

    // Auto rotation.
    a = edge_n;
    auto_mode = 1'b1;
    expect_at(a + 8,  2'd0, 32'hA0, 1'b0);
    expect_at(a + 9,  2'd1, 32'hA0, 1'b0);
    expect_at(a + 10, 2'd1, 32'hB1, 1'b0);
    expect_at(a + 16, 2'd1, 32'hB1, 1'b0);
    expect_at(a + 17, 2'd2, 32'hB1, 1'b0);
    expect_at(a + 25, 2'd3, 32'hC2, 1'b0);
    expect_at(a + 33, 2'd0, 32'hD3, 1'b0);
    expect_at(a + 34, 2'd0, 32'hA0, 1'b0);

    // Press mid-dwell restarts the dwell.
    wait_edge(a + 30);
    change = 1'b1;
    expect_at(a + 36, 2'd0, 32'hA0, 1'b0);
    expect_at(a + 37, 2'd1, 32'hA0, 1'b0);
    expect_at(a + 44, 2'd1, 32'hB1, 1'b0);
    expect_at(a + 45, 2'd2, 32'hB1, 1'b0);

    // Hold at Sel=2 with a press arriving during hold.
    wait_edge(a + 48);
    hold_req = 1'b1;
    expect_at(a + 49, 2'd2, 32'hC2, 1'b1);
    expect_at(a + 50, 2'd2, HOLDV, 1'b1);
    wait_edge(a + 50);
    change = 1'b0;
    wait_edge(a + 58);
    change = 1'b1;
    expect_at(a + 60, 2'd2, HOLDV, 1'b1);
    expect_at(a + 66, 2'd2, HOLDV, 1'b1);
    expect_at(a + 68, 2'd2, HOLDV, 1'b1);
    wait_edge(a + 68);
    hold_req = 1'b0;
    expect_at(a + 69, 2'd2, HOLDV, 1'b0);
    expect_at(a + 70, 2'd2, 32'hC2, 1'b0);
    expect_at(a + 76, 2'd2, 32'hC2, 1'b0);
    expect_at(a + 77, 2'd3, 32'hC2, 1'b0);
    expect_at(a + 78, 2'd3, 32'hD3, 1'b0);
    wait_edge(a + 70);
    change = 1'b0;

    // Leaving auto freezes Sel.
    wait_edge(a + 78);
    auto_mode = 1'b0;
    expect_at(a + 79, 2'd3, 32'hD3, 1'b0);
    expect_at(a + 86, 2'd3, 32'hD3, 1'b0);
    expect_at(a + 95, 2'd3, 32'hD3, 1'b0);

    // Reset during hold and a half-done debounce.
    wait_edge(a + 100);
    r = edge_n;
    hold_req = 1'b1;
    change = 1'b1;
    expect_at(r + 1, 2'd3, 32'hD3, 1'b1);
    expect_at(r + 2, 2'd3, HOLDV, 1'b1);
    wait_edge(r + 3);
    rst_n = 1'b0;
    expect_at(r + 4,  2'd0, 32'd0, 1'b0);
    expect_at(r + 5,  2'd0, 32'd0, 1'b0);
    expect_at(r + 6,  2'd0, 32'hA0, 1'b0);
    expect_at(r + 11, 2'd0, 32'hA0, 1'b0);
    expect_at(r + 12, 2'd1, 32'hA0, 1'b0);
    expect_at(r + 13, 2'd1, 32'hB1, 1'b0);
    wait_edge(r + 5);
    rst_n = 1'b1;
    hold_req = 1'b0;
    wait_edge(r + 20);
    change = 1'b0;
    wait_edge(r + 40);

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_display_scheduler.md
Name: led_display_scheduler

Overview:
Sequences the board LED display between four 32-bit sources: program LED data, total cycles, taken-branch cycles, and untaken-branch cycles. Three modes:
- Manual: a debounced push-button steps through the sources.
- Auto-rotate: a dwell counter steps through the sources.
- Hold: a CPU override forces a fifth value onto the LEDs.

Sits between the CPU/counter datapath and the top-level LED pins.

Parameters:
DEBOUNCE_CYCLES, 20, consecutive stable cycles needed to accept a button level change (≥2)
DWELL_CYCLES, 100, cycles each source is shown in auto mode (≥2)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, synchronous, active-low
Src0  in  32  LED data (Sel=0)
Src1  in  32  total cycle count (Sel=1)
Src2  in  32  taken-branch cycle count (Sel=2)
Src3  in  32  untaken-branch cycle count (Sel=3)
Change  in  1  raw push-button, asynchronous, may bounce
AutoMode  in  1  level; 1 = auto-rotate requested
HoldReq  in  1  level; CPU override request
HoldData  in  32  value shown while in HOLD
HoldAck  out  1  1 while FSM is in HOLD (registered)
Sel  out  2  current source index (registered)
LedShow  out  32  displayed value (registered)

Behaviour:
- Reset (RST=0 at a rising edge) sets:
  - state=MANUAL, Sel=0, LedShow=0, HoldAck=0
  - dwell counter=0, debounce counter=0
  - sync flops=0, debounced level=0, press pulse=0
- Reset has priority over everything and aborts any debounce, dwell or hold in progress.
- Synchroniser: two flops on Change give sync2.
- Debounce:
  - If sync2 != stable, dbcnt increments. When dbcnt == DEBOUNCE_CYCLES-1 and sync2 still differs: stable<=sync2, dbcnt<=0.
  - If sync2 == stable, dbcnt<=0. A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - press (registered, 1 cycle) is set on the edge where stable goes 0->1. The release (1->0) produces no pulse.
  - Latency: Change held high from before edge 1 gives stable=1 and press=1 after edge 2+DEBOUNCE_CYCLES. Sel updates at edge 3+DEBOUNCE_CYCLES; LedShow updates at edge 4+DEBOUNCE_CYCLES.
- FSM states: MANUAL, AUTO, HOLD. Per-cycle priority is HoldReq > AutoMode > press/dwell.
- MANUAL:
  - HoldReq=1 -> HOLD.
  - Else AutoMode=1 -> AUTO, dwell<=0.
  - Else press -> Sel<=Sel+1.
- AUTO:
  - HoldReq=1 -> HOLD.
  - Else AutoMode=0 -> MANUAL; Sel kept, dwell<=0.
  - Else press -> Sel<=Sel+1, dwell<=0 (a manual step restarts the dwell).
  - Else if dwell == DWELL_CYCLES-1 -> Sel<=Sel+1, dwell<=0.
  - Else dwell<=dwell+1.
- HOLD:
  - Sel and dwell are frozen; press pulses are discarded (not queued).
  - HoldReq=0 -> AUTO if AutoMode=1, else MANUAL; dwell<=0.
- Sel arithmetic is 2-bit modulo 4: 3+1 -> 0.
- A press and a dwell expiry in the same AUTO cycle advance Sel by exactly 1.
- HoldAck=1 exactly when the registered state is HOLD. It rises one edge after HoldReq is sampled high and falls one edge after HoldReq is sampled low.
- LedShow(t+1) = HoldData(t) if state(t)==HOLD, else Src[Sel(t)](t).
  - Sources are re-sampled every cycle, so a live counter keeps updating on the LEDs.
  - LedShow lags Sel/state by one cycle.
- The debounce logic runs in all states, including HOLD.

Test Plan:
Use DEBOUNCE_CYCLES=4, DWELL_CYCLES=8, Src0..3 = 0xA0,0xB1,0xC2,0xD3, HoldData=0xFFFF0000.
- Reset: hold RST=0 for 3 cycles with inputs toggling -> Sel=0, LedShow=0, HoldAck=0. After release, LedShow=0xA0 one cycle later.
- Clean press: Change high for 20 cycles from edge 1 -> press pulse once, Sel=1 at edge 7, LedShow=0xB1 at edge 8. Four more clean presses -> Sel sequence 2,3,0,1 (wrap).
- Bounce: Change pulses high for 3 cycles, low 2, high 3, then low -> Sel never changes. Change held high for 4+ cycles after that -> exactly one increment.
- Auto-rotate: AutoMode=1 from Sel=0 -> Sel steps 1,2,3,0 every 8 cycles. A press mid-dwell -> immediate +1 and the next auto step lands 8 cycles after the press-driven step. AutoMode=0 -> Sel frozen.
- Hold: in AUTO at Sel=2 assert HoldReq for 20 cycles with presses in between -> HoldAck=1 one edge later, LedShow=0xFFFF0000, Sel stays 2. On release -> HoldAck=0, return to AUTO, dwell restarts from 0, and presses made during HOLD are lost.
- Reset mid-operation: RST=0 during HOLD and during a half-completed debounce -> all state clears to reset values. A press that resumes after reset needs the full 2+DEBOUNCE_CYCLES again.
